barrel_aligner: RTL and testbench

Receive-side counterpart of the byte barrel rotator: accepts a byte stream rotated right by an unknown, constant amount, finds that amount by hunting for a framed sync byte, and outputs de-rotated bytes once lock is confirmed. It sits directly downstream of the rotator (or a link that rotates bit positions) and feeds byte-aligned, frame-marked data to the consumer.

---
 rtl/barrel_pkg.sv | 28 ++
 rtl/barrel_sync_match.sv | 24 ++
 rtl/barrel_aligner.sv | 133 +++++++++++++
 tb/tb_barrel_aligner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared types and rotate helpers for the byte barrel rotator/aligner pair.
package barrel_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [7:0]  DEF_SYNC      = 8'hA5;
    localparam int unsigned DEF_FRAME_LEN = 8;
    localparam int unsigned DEF_LOCK_N    = 3;
    localparam int unsigned DEF_LOSS_N    = 2;

    // Rotates by shifting a doubled copy of the byte.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] k);
        logic [15:0] t;
        t = {x, x} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] k);
        logic [15:0] t;
        t = {x, x} >> k;
        return t[7:0];
    endfunction

endpackage

// File: rtl/barrel_sync_match.sv
// Compares every left rotation of the input byte against the sync pattern;
// the smallest matching rotation wins.
module barrel_sync_match
    import barrel_pkg::*;
#(
    parameter logic [7:0] SYNC = DEF_SYNC
) (
    input  logic [7:0] data_in,
    output logic       hit,
    output logic [2:0] k
);

    always_comb begin
        hit = 1'b0;
        k   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!hit && (rotl8(data_in, 3'(i)) == SYNC)) begin
                hit = 1'b1;
                k   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/barrel_aligner.sv
// Finds the unknown byte rotation by hunting for a framed sync byte and
// outputs de-rotated, frame-marked bytes while locked.
module barrel_aligner
    import barrel_pkg::*;
#(
    parameter logic [7:0]  SYNC      = DEF_SYNC,
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
    parameter int unsigned LOCK_N    = DEF_LOCK_N,
    parameter int unsigned LOSS_N    = DEF_LOSS_N
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sof,
    output logic       locked,
    output logic [2:0] rot
);

    localparam int unsigned POS_W  = $clog2(FRAME_LEN);
    localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_N + 1);

    state_t              state, state_n;
    logic [POS_W-1:0]    pos, pos_n, pos_inc;
    logic [GOOD_W-1:0]   good_cnt, good_n;
    logic [MISS_W-1:0]   miss_cnt, miss_n;
    logic [2:0]          rot_n;
    logic [7:0]          dout_n, aligned;
    logic                vout_n, sof_n;
    logic                hit, sync_slot, rot_ok;
    logic [2:0]          hit_k;

    barrel_sync_match #(.SYNC(SYNC)) u_match (
        .data_in (data_in),
        .hit     (hit),
        .k       (hit_k)
    );

    assign aligned   = rotl8(data_in, rot);
    assign sync_slot = (pos == '0);
    assign rot_ok    = (aligned == SYNC);
    assign pos_inc   = (pos == POS_W'(FRAME_LEN - 1)) ? '0 : pos + POS_W'(1);

    always_comb begin
        state_n = state;
        pos_n   = pos;
        good_n  = good_cnt;
        miss_n  = miss_cnt;
        rot_n   = rot;
        dout_n  = data_out;
        vout_n  = 1'b0;
        sof_n   = 1'b0;
        if (valid_in) begin
            case (state)
                HUNT: begin
                    if (hit) begin
                        rot_n   = hit_k;
                        good_n  = GOOD_W'(1);
                        pos_n   = POS_W'(1);
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!sync_slot) begin
                        pos_n = pos_inc;
                    end else if (rot_ok) begin
                        pos_n = pos_inc;
                        if (good_cnt == GOOD_W'(LOCK_N - 1)) begin
                            state_n = LOCKED;
                            good_n  = '0;
                            vout_n  = 1'b1;
                            sof_n   = 1'b1;
                            dout_n  = aligned;
                        end else begin
                            good_n = good_cnt + GOOD_W'(1);
                        end
                    end else begin
                        // The failing byte is deliberately not re-hunted.
                        state_n = HUNT;
                        good_n  = '0;
                        pos_n   = '0;
                    end
                end
                LOCKED: begin
                    if (sync_slot && !rot_ok && (miss_cnt == MISS_W'(LOSS_N - 1))) begin
                        state_n = HUNT;
                        miss_n  = '0;
                        pos_n   = '0;
                    end else begin
                        pos_n  = pos_inc;
                        vout_n = 1'b1;
                        dout_n = aligned;
                        if (sync_slot) begin
                            sof_n  = rot_ok;
                            miss_n = rot_ok ? '0 : miss_cnt + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            pos       <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            rot       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            sof       <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            good_cnt  <= good_n;
            miss_cnt  <= miss_n;
            rot       <= rot_n;
            data_out  <= dout_n;
            valid_out <= vout_n;
            sof       <= sof_n;
            locked    <= (state_n == LOCKED);
        end
    end

endmodule

// File: tb/tb_barrel_aligner.sv
// Directed table-driven bench for barrel_aligner with hand-computed expectations.
module tb_barrel_aligner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       valid_out, sof, locked;
    logic [2:0] rot;

    int checks = 0;
    int errors = 0;

    barrel_aligner #(
        .SYNC      (8'hA5),
        .FRAME_LEN (8),
        .LOCK_N    (3),
        .LOSS_N    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sof       (sof),
        .locked    (locked),
        .rot       (rot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       evo;
        logic       esof;
        logic       elock;
        logic [2:0] erot;
        logic       cdo;
        logic [7:0] edo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [7:0] d,
                       input logic evo, input logic esof, input logic elock,
                       input logic [2:0] erot, input logic cdo, input logic [7:0] edo);
        vec_t e;
        e.rst = rst; e.v = v; e.d = d; e.evo = evo; e.esof = esof;
        e.elock = elock; e.erot = erot; e.cdo = cdo; e.edo = edo;
        vecs.push_back(e);
    endtask

    // One 8-byte frame: sync byte s, then seven copies of payload p.
    task automatic frame(input logic [7:0] s, input logic [7:0] p,
                         input logic s_vo, input logic s_sof, input logic s_lk, input logic [7:0] s_do,
                         input logic p_vo, input logic p_lk, input logic [2:0] r,
                         input logic [7:0] p_do, input logic gaps);
        add(1'b0, 1'b1, s, s_vo, s_sof, s_lk, r, s_vo, s_do);
        if (gaps) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, s_lk, r, s_vo, s_do);
        for (int unsigned i = 1; i < 8; i++) begin
            add(1'b0, 1'b1, p, p_vo, 1'b0, p_lk, r, p_vo, p_do);
            if (gaps) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, p_lk, r, p_vo, p_do);
        end
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h want %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00);
        // acquire at rotation 3
        frame(8'hB4, 8'h20, 0, 0, 0, 8'h00, 0, 0, 3'd3, 8'h00, 0);
        frame(8'hB4, 8'h20, 0, 0, 0, 8'h00, 0, 0, 3'd3, 8'h00, 0);
        frame(8'hB4, 8'h20, 1, 1, 1, 8'hA5, 1, 1, 3'd3, 8'h01, 0);
        // single miss, then a good sync clears it
        frame(8'h00, 8'h20, 1, 0, 1, 8'h00, 1, 1, 3'd3, 8'h01, 0);
        frame(8'hB4, 8'h20, 1, 1, 1, 8'hA5, 1, 1, 3'd3, 8'h01, 0);
        // two consecutive misses drop lock; rot holds
        frame(8'h00, 8'h20, 1, 0, 1, 8'h00, 1, 1, 3'd3, 8'h01, 0);
        frame(8'h00, 8'h20, 0, 0, 0, 8'h00, 0, 0, 3'd3, 8'h00, 0);
        // reacquire
        frame(8'hB4, 8'h20, 0, 0, 0, 8'h00, 0, 0, 3'd3, 8'h00, 0);
        frame(8'hB4, 8'h20, 0, 0, 0, 8'h00, 0, 0, 3'd3, 8'h00, 0);
        frame(8'hB4, 8'h20, 1, 1, 1, 8'hA5, 1, 1, 3'd3, 8'h01, 0);
        // partial frame, then reset with valid_in high and a sync byte present
        add(1'b0, 1'b1, 8'hB4, 1, 1, 1, 3'd3, 1, 8'hA5);
        for (int unsigned i = 0; i < 3; i++) add(1'b0, 1'b1, 8'h20, 1, 0, 1, 3'd3, 1, 8'h01);
        add(1'b1, 1'b1, 8'hB4, 0, 0, 0, 3'd0, 1, 8'h00);
        // false hunt: lone B4, then a rotation-5 sync at the sync slot (not re-hunted)
        add(1'b0, 1'b1, 8'h20, 0, 0, 0, 3'd0, 1, 8'h00);
        add(1'b0, 1'b1, 8'h20, 0, 0, 0, 3'd0, 1, 8'h00);
        add(1'b0, 1'b1, 8'hB4, 0, 0, 0, 3'd3, 1, 8'h00);
        for (int unsigned i = 0; i < 7; i++) add(1'b0, 1'b1, 8'h20, 0, 0, 0, 3'd3, 1, 8'h00);
        add(1'b0, 1'b1, 8'h2D, 0, 0, 0, 3'd3, 1, 8'h00);
        // relock needs three full frames
        frame(8'hB4, 8'h20, 0, 0, 0, 8'h00, 0, 0, 3'd3, 8'h00, 0);
        frame(8'hB4, 8'h20, 0, 0, 0, 8'h00, 0, 0, 3'd3, 8'h00, 0);
        frame(8'hB4, 8'h20, 1, 1, 1, 8'hA5, 1, 1, 3'd3, 8'h01, 0);
        // gapped stream at rotation 5
        add(1'b1, 1'b0, 8'h00, 0, 0, 0, 3'd0, 1, 8'h00);
        frame(8'h2D, 8'h08, 0, 0, 0, 8'h00, 0, 0, 3'd5, 8'h00, 1);
        frame(8'h2D, 8'h08, 0, 0, 0, 8'h00, 0, 0, 3'd5, 8'h00, 1);
        frame(8'h2D, 8'h08, 1, 1, 1, 8'hA5, 1, 1, 3'd5, 8'h01, 1);

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            valid_in = vecs[i].v;
            data_in  = vecs[i].d;
            @(posedge clk);
            #1;
            check("valid_out", i, {7'd0, valid_out}, {7'd0, vecs[i].evo});
            check("sof",       i, {7'd0, sof},       {7'd0, vecs[i].esof});
            check("locked",    i, {7'd0, locked},    {7'd0, vecs[i].elock});
            check("rot",       i, {5'd0, rot},       {5'd0, vecs[i].erot});
            if (vecs[i].cdo) check("data_out", i, data_out, vecs[i].edo);
        end

        // idle while locked: lock and data hold, valid_out stays low
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h2D;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_vo",   1000 + i, {7'd0, valid_out}, 8'h00);
            check("idle_lock", 1000 + i, {7'd0, locked},    8'h01);
            check("idle_do",   1000 + i, data_out,          8'h01);
        end

        // one contiguous frame after the idle gap keeps framing
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            data_in  = (i == 0) ? 8'h2D : 8'h08;
            @(posedge clk);
            #1;
            check("tail_vo",  2000 + i, {7'd0, valid_out}, 8'h01);
            check("tail_sof", 2000 + i, {7'd0, sof},       (i == 0) ? 8'h01 : 8'h00);
            check("tail_do",  2000 + i, data_out,          (i == 0) ? 8'hA5 : 8'h01);
        end
        valid_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
